slc3_ctrl_fsm: RTL

Parametrised SLC-3 instruction sequencer and decoder, the successor to the fixed-latency ISDU. It drives all datapath load, gate and mux selects and the SRAM strobes. Memory read/write wait states are configurable via parameters and share one wait counter. It adds JSR/JSRR, single-cycle register-and-CC writeback, and defined handling of illegal opcodes. It sits between the IR/BEN logic and the SLC-3 datapath in the top level.

---
 rtl/slc3_pkg.sv | 37 +++
 rtl/slc3_wait_timer.sv | 32 +++
 rtl/slc3_ctrl_fsm.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/slc3_pkg.sv
// Shared types and encodings for the SLC-3 control sequencer: state enum,
// opcodes, datapath mux/ALU select codes and the wait-counter width.
package slc3_pkg;

    typedef enum logic [4:0] {
        HALTED, FETCH, RD_WAIT, RD_LATCH, IR_LOAD, DECODE, EXE_ALU,
        BR_TEST, BR_TAKE, LDR_ADDR, LDR_WB, STR_ADDR, STR_DATA, STR_WR,
        JSR_LINK, JSR_OFF, JSRR, JMP, PAUSE1, PAUSE2
    } state_t;

    localparam logic [3:0] OP_BR    = 4'b0000;
    localparam logic [3:0] OP_ADD   = 4'b0001;
    localparam logic [3:0] OP_JSR   = 4'b0100;
    localparam logic [3:0] OP_AND   = 4'b0101;
    localparam logic [3:0] OP_LDR   = 4'b0110;
    localparam logic [3:0] OP_STR   = 4'b0111;
    localparam logic [3:0] OP_NOT   = 4'b1001;
    localparam logic [3:0] OP_JMP   = 4'b1100;
    localparam logic [3:0] OP_PAUSE = 4'b1101;

    localparam logic [1:0] ALUK_ADD  = 2'b00;
    localparam logic [1:0] ALUK_AND  = 2'b01;
    localparam logic [1:0] ALUK_NOT  = 2'b10;
    localparam logic [1:0] ALUK_PASS = 2'b11;

    localparam logic [1:0] PCMUX_INC   = 2'b00;
    localparam logic [1:0] PCMUX_ADDER = 2'b01;
    localparam logic [1:0] PCMUX_BUS   = 2'b10;

    localparam logic [1:0] A2_ZERO  = 2'b00;
    localparam logic [1:0] A2_OFF6  = 2'b01;
    localparam logic [1:0] A2_OFF9  = 2'b10;
    localparam logic [1:0] A2_OFF11 = 2'b11;

    localparam int WAIT_W = $clog2(16);

endpackage

// File: rtl/slc3_wait_timer.sv
// Shared down-counter for memory read wait states and store write hold.
// done is high whenever the count has reached zero.
module slc3_wait_timer
    import slc3_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [WAIT_W-1:0] load_val,
    output logic              done
);

    logic [WAIT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load)
            cnt_d = load_val;
        else if (cnt_q != '0)
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign done = (cnt_q == '0);

endmodule

// File: rtl/slc3_ctrl_fsm.sv
// SLC-3 sequencer/decoder driving datapath loads, gates, mux selects and SRAM
// strobes. Optional macro SLC3_PAUSE_EN adds the PAUSE1/PAUSE2 handshake.
module slc3_ctrl_fsm
    import slc3_pkg::*;
#(
    parameter int unsigned MEM_WAIT = 2,
    parameter int unsigned WR_HOLD  = 3
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Run,
    input  logic       Continue,
    input  logic [3:0] Opcode,
    input  logic       IR_5,
    input  logic       IR_11,
    input  logic       BEN,
    output logic       LD_MAR,
    output logic       LD_MDR,
    output logic       LD_IR,
    output logic       LD_BEN,
    output logic       LD_CC,
    output logic       LD_REG,
    output logic       LD_PC,
    output logic       LD_LED,
    output logic       GatePC,
    output logic       GateMDR,
    output logic       GateALU,
    output logic       GateMARMUX,
    output logic [1:0] PCMUX,
    output logic       DRMUX,
    output logic       SR1MUX,
    output logic       SR2MUX,
    output logic       ADDR1MUX,
    output logic [1:0] ADDR2MUX,
    output logic [1:0] ALUK,
    output logic       Mem_CE,
    output logic       Mem_UB,
    output logic       Mem_LB,
    output logic       Mem_OE,
    output logic       Mem_WE,
    output logic [4:0] state_show
);

    localparam logic [WAIT_W-1:0] RD_LOAD = (MEM_WAIT == 0) ? '0 : WAIT_W'(MEM_WAIT - 1);
    localparam logic [WAIT_W-1:0] WR_LOAD = WAIT_W'(WR_HOLD - 1);

    state_t            state_q, state_d;
    logic              ret_ldr_q, ret_ldr_d;   // read sequence returns to LDR_WB
    logic              t_load, t_done;
    logic [WAIT_W-1:0] t_val;

    slc3_wait_timer u_timer (
        .clk      (Clk),
        .reset    (Reset),
        .load     (t_load),
        .load_val (t_val),
        .done     (t_done)
    );

    always_comb begin
        state_d    = state_q;
        ret_ldr_d  = ret_ldr_q;
        t_load     = 1'b0;
        t_val      = '0;
        LD_MAR     = 1'b0;  LD_MDR  = 1'b0;  LD_IR   = 1'b0;  LD_BEN     = 1'b0;
        LD_CC      = 1'b0;  LD_REG  = 1'b0;  LD_PC   = 1'b0;
        GatePC     = 1'b0;  GateMDR = 1'b0;  GateALU = 1'b0;  GateMARMUX = 1'b0;
        PCMUX      = PCMUX_INC;
        DRMUX      = 1'b0;  SR1MUX  = 1'b0;  SR2MUX  = 1'b0;  ADDR1MUX   = 1'b0;
        ADDR2MUX   = A2_ZERO;
        ALUK       = ALUK_ADD;
        Mem_OE     = 1'b1;
        Mem_WE     = 1'b1;
        case (state_q)
            HALTED: if (Run) state_d = FETCH;
            FETCH: begin
                GatePC = 1'b1; LD_MAR = 1'b1; LD_PC = 1'b1; PCMUX = PCMUX_INC;
                ret_ldr_d = 1'b0;
                if (MEM_WAIT == 0) state_d = RD_LATCH;
                else begin state_d = RD_WAIT; t_load = 1'b1; t_val = RD_LOAD; end
            end
            RD_WAIT: begin
                Mem_OE = 1'b0;
                if (t_done) state_d = RD_LATCH;
            end
            RD_LATCH: begin
                Mem_OE = 1'b0; LD_MDR = 1'b1;
                state_d = ret_ldr_q ? LDR_WB : IR_LOAD;
            end
            IR_LOAD: begin
                GateMDR = 1'b1; LD_IR = 1'b1; state_d = DECODE;
            end
            DECODE: begin
                LD_BEN = 1'b1;
                case (Opcode)
                    OP_ADD, OP_AND, OP_NOT: state_d = EXE_ALU;
                    OP_BR:  state_d = BR_TEST;
                    OP_LDR: state_d = LDR_ADDR;
                    OP_STR: state_d = STR_ADDR;
                    OP_JSR: state_d = JSR_LINK;
                    OP_JMP: state_d = JMP;
`ifdef SLC3_PAUSE_EN
                    OP_PAUSE: state_d = PAUSE1;
`endif
                    default: state_d = FETCH;
                endcase
            end
            EXE_ALU: begin
                GateALU = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1;
                case (Opcode)
                    OP_AND:  ALUK = ALUK_AND;
                    OP_NOT:  ALUK = ALUK_NOT;
                    default: ALUK = ALUK_ADD;
                endcase
                SR2MUX  = (Opcode == OP_ADD || Opcode == OP_AND) ? IR_5 : 1'b0;
                state_d = FETCH;
            end
            BR_TEST: state_d = BEN ? BR_TAKE : FETCH;
            BR_TAKE: begin
                ADDR2MUX = A2_OFF9; PCMUX = PCMUX_ADDER; LD_PC = 1'b1; state_d = FETCH;
            end
            LDR_ADDR, STR_ADDR: begin
                ADDR1MUX = 1'b1; ADDR2MUX = A2_OFF6; GateMARMUX = 1'b1; LD_MAR = 1'b1;
                if (state_q == STR_ADDR) state_d = STR_DATA;
                else begin
                    ret_ldr_d = 1'b1;
                    if (MEM_WAIT == 0) state_d = RD_LATCH;
                    else begin state_d = RD_WAIT; t_load = 1'b1; t_val = RD_LOAD; end
                end
            end
            LDR_WB: begin
                GateMDR = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1; state_d = FETCH;
            end
            STR_DATA: begin
                SR1MUX = 1'b1; ALUK = ALUK_PASS; GateALU = 1'b1; LD_MDR = 1'b1;
                t_load = 1'b1; t_val = WR_LOAD; state_d = STR_WR;
            end
            STR_WR: begin
                Mem_WE = 1'b0;
                if (t_done) state_d = FETCH;
            end
            JSR_LINK: begin
                GatePC = 1'b1; DRMUX = 1'b1; LD_REG = 1'b1;
                state_d = IR_11 ? JSR_OFF : JSRR;
            end
            JSR_OFF: begin
                ADDR2MUX = A2_OFF11; PCMUX = PCMUX_ADDER; LD_PC = 1'b1; state_d = FETCH;
            end
            JSRR, JMP: begin
                ADDR1MUX = 1'b1; PCMUX = PCMUX_ADDER; LD_PC = 1'b1; state_d = FETCH;
            end
`ifdef SLC3_PAUSE_EN
            PAUSE1: if (Continue) state_d = PAUSE2;
            PAUSE2: if (!Continue) state_d = FETCH;
`endif
            default: state_d = HALTED;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= HALTED;
            ret_ldr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ret_ldr_q <= ret_ldr_d;
        end
    end

`ifdef SLC3_PAUSE_EN
    // Marks that PAUSE1 has already shown its LED pulse.
    logic led_done_q, led_done_d;
    assign led_done_d = (state_q == PAUSE1);
    always_ff @(posedge Clk) begin
        if (Reset) led_done_q <= 1'b0;
        else       led_done_q <= led_done_d;
    end
    assign LD_LED = (state_q == PAUSE1) && !led_done_q;
`else
    logic unused_continue;
    assign unused_continue = Continue;
    assign LD_LED = 1'b0;
`endif

    assign Mem_CE     = 1'b0;
    assign Mem_UB     = 1'b0;
    assign Mem_LB     = 1'b0;
    assign state_show = state_q;

endmodule
